// File: rtl/axis_oscilloscope_reader.sv
// axis_oscilloscope_reader: streams a ring-buffer capture out of BRAM onto AXI4-Stream in time order.
// Ports:
//   aclk, aresetn          clock and synchronous active-low reset
//   start_flag             level start request, honoured only while idle
//   start_addr, len_data   first ring address and word count minus one, sampled at start
//   sts_data               {words_sent, busy}
//   bram_porta_*           read port of the capture BRAM (1-cycle read latency)
//   m_axis_*               AXI4-Stream master carrying the samples, tlast on the final word
module axis_oscilloscope_reader #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 12
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        start_flag,
    input  logic [CNTR_WIDTH-1:0]       start_addr,
    input  logic [CNTR_WIDTH-1:0]       len_data,
    output logic [CNTR_WIDTH:0]         sts_data,
    output logic                        bram_porta_clk,
    output logic                        bram_porta_rst,
    output logic [CNTR_WIDTH-1:0]       bram_porta_addr,
    input  logic [AXIS_TDATA_WIDTH-1:0] bram_porta_rddata,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [CNTR_WIDTH-1:0]   addr_q, addr_d;
    logic [CNTR_WIDTH-1:0]   remaining_q, remaining_d;
    logic [CNTR_WIDTH-1:0]   words_sent_q, words_sent_d;
    logic                    inflight_q, inflight_d;
    logic                    inflight_last_q, inflight_last_d;
    logic [1:0]              count_q, count_d;
    logic                    wr_ptr_q, wr_ptr_d;
    logic                    rd_ptr_q, rd_ptr_d;
    // Each buffer entry carries {last, data} so tlast travels with its word.
    logic [AXIS_TDATA_WIDTH:0] mem_q [2];

    logic       pop;
    logic       issue;
    logic [2:0] occupancy;

    assign pop       = m_axis_tvalid & m_axis_tready;
    // Words that will be held once the outstanding read lands; keeps the 2-entry buffer from overflowing.
    assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue     = (state_q == RUN) && (occupancy < 3'd2);

    assign bram_porta_clk  = aclk;
    assign bram_porta_rst  = ~aresetn;
    assign bram_porta_addr = addr_q;
    assign m_axis_tvalid   = (count_q != 2'd0);
    assign m_axis_tdata    = mem_q[rd_ptr_q][AXIS_TDATA_WIDTH-1:0];
    assign m_axis_tlast    = m_axis_tvalid & mem_q[rd_ptr_q][AXIS_TDATA_WIDTH];
    assign sts_data        = {words_sent_q, state_q != IDLE};

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        remaining_d     = remaining_q;
        words_sent_d    = words_sent_q + CNTR_WIDTH'(pop);
        inflight_d      = issue;
        inflight_last_d = issue && (remaining_q == '0);
        count_d         = count_q + {1'b0, inflight_q} - {1'b0, pop};
        wr_ptr_d        = wr_ptr_q ^ inflight_q;
        rd_ptr_d        = rd_ptr_q ^ pop;
        case (state_q)
            IDLE: begin
                if (start_flag) begin
                    state_d      = RUN;
                    addr_d       = start_addr;
                    remaining_d  = len_data;
                    words_sent_d = '0;
                end
            end
            RUN: begin
                if (issue) begin
                    addr_d      = addr_q + CNTR_WIDTH'(1);
                    remaining_d = remaining_q - CNTR_WIDTH'(1);
                    state_d     = (remaining_q == '0) ? DRAIN : RUN;
                end
            end
            DRAIN: begin
                if (pop && m_axis_tlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            remaining_q     <= '0;
            words_sent_q    <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            count_q         <= 2'd0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            remaining_q     <= remaining_d;
            words_sent_q    <= words_sent_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            count_q         <= count_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
        end
    end

    // Read data arrives the cycle after an issue and is captured unconditionally then.
    always_ff @(posedge aclk) begin
        if (inflight_q) mem_q[wr_ptr_q] <= {inflight_last_q, bram_porta_rddata};
    end

endmodule

// File: tb/tb_axis_oscilloscope_reader.sv
// tb_axis_oscilloscope_reader: directed self-checking bench for the ring-buffer stream reader.
module tb_axis_oscilloscope_reader;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        start_flag;
    logic [11:0] start_addr;
    logic [11:0] len_data;
    logic [12:0] sts_data;
    logic        bram_porta_clk;
    logic        bram_porta_rst;
    logic [11:0] bram_porta_addr;
    logic [31:0] bram_porta_rddata;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;

    int checks = 0;
    int fails  = 0;

    always #5 aclk = ~aclk;

    // BRAM model: BRAM[i] = i, one cycle read latency.
    always @(posedge aclk) bram_porta_rddata <= {20'h0, bram_porta_addr};

    axis_oscilloscope_reader #(.AXIS_TDATA_WIDTH(32), .CNTR_WIDTH(12)) dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .start_flag        (start_flag),
        .start_addr        (start_addr),
        .len_data          (len_data),
        .sts_data          (sts_data),
        .bram_porta_clk    (bram_porta_clk),
        .bram_porta_rst    (bram_porta_rst),
        .bram_porta_addr   (bram_porta_addr),
        .bram_porta_rddata (bram_porta_rddata),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tready     (m_axis_tready),
        .m_axis_tlast      (m_axis_tlast)
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic start_readout(input logic [11:0] a, input logic [11:0] l);
        start_addr = a;
        len_data   = l;
        start_flag = 1'b1;
        tick();
        start_flag = 1'b0;
    endtask

    task automatic test_reset();
        aresetn       = 1'b0;
        start_flag    = 1'b0;
        start_addr    = 12'h0;
        len_data      = 12'h0;
        m_axis_tready = 1'b0;
        repeat (3) tick();
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: tvalid=%b tlast=%b, expected 0 0", m_axis_tvalid, m_axis_tlast);
        end
        checks++;
        if (sts_data !== 13'h0 || bram_porta_addr !== 12'h0) begin
            fails++;
            $display("FAIL reset_status: sts=%h addr=%h, expected 0 0", sts_data, bram_porta_addr);
        end
        checks++;
        if (bram_porta_rst !== 1'b1) begin
            fails++;
            $display("FAIL reset_bram_rst: got %b expected 1", bram_porta_rst);
        end
        aresetn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        m_axis_tready = 1'b1;
        start_readout(12'h010, 12'd7);
        checks++;
        if (bram_porta_addr !== 12'h010 || sts_data[0] !== 1'b1) begin
            fails++;
            $display("FAIL basic_start: addr=%h busy=%b, expected 010 1", bram_porta_addr, sts_data[0]);
        end
        tick();
        checks++;
        if (m_axis_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL basic_latency: tvalid=%b one cycle early, expected 0", m_axis_tvalid);
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'(32'h10 + i) || m_axis_tlast !== (i == 7)) begin
                fails++;
                $display("FAIL basic_word%0d: valid=%b data=%h last=%b, expected 1 %h %b",
                         i, m_axis_tvalid, m_axis_tdata, m_axis_tlast, 32'(32'h10 + i), (i == 7));
            end
            tick();
        end
        checks++;
        if (sts_data !== {12'd8, 1'b0} || m_axis_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL basic_done: sts=%h valid=%b, expected 010 0", sts_data, m_axis_tvalid);
        end
    endtask

    task automatic test_wrap();
        logic [11:0] e;
        m_axis_tready = 1'b1;
        start_readout(12'hFFE, 12'd3);
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            e = 12'hFFE + 12'(i);
            checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== {20'h0, e} || m_axis_tlast !== (i == 3)) begin
                fails++;
                $display("FAIL wrap_word%0d: valid=%b data=%h last=%b, expected 1 %h %b",
                         i, m_axis_tvalid, m_axis_tdata, m_axis_tlast, e, (i == 3));
            end
            tick();
        end
        checks++;
        if (sts_data !== {12'd4, 1'b0}) begin
            fails++;
            $display("FAIL wrap_done: sts=%h expected %h", sts_data, {12'd4, 1'b0});
        end
    endtask

    task automatic test_backpressure();
        int          n   = 0;
        int          cyc = 0;
        logic        pv  = 1'b0;
        logic        pr  = 1'b0;
        logic        pl  = 1'b0;
        logic [31:0] pd  = '0;
        m_axis_tready = 1'b0;
        start_readout(12'h100, 12'd15);
        while (n < 16 && cyc < 400) begin
            if (pv && !pr) begin
                checks++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== pd || m_axis_tlast !== pl) begin
                    fails++;
                    $display("FAIL bp_stable: valid=%b data=%h last=%b, expected 1 %h %b",
                             m_axis_tvalid, m_axis_tdata, m_axis_tlast, pd, pl);
                end
            end
            m_axis_tready = 1'($urandom_range(0, 1));
            if (m_axis_tvalid && m_axis_tready) begin
                checks++;
                if (m_axis_tdata !== 32'(32'h100 + n) || m_axis_tlast !== (n == 15)) begin
                    fails++;
                    $display("FAIL bp_word%0d: data=%h last=%b, expected %h %b",
                             n, m_axis_tdata, m_axis_tlast, 32'(32'h100 + n), (n == 15));
                end
                n++;
            end
            pv = m_axis_tvalid;
            pr = m_axis_tready;
            pd = m_axis_tdata;
            pl = m_axis_tlast;
            tick();
            cyc++;
        end
        checks++;
        if (n !== 16) begin
            fails++;
            $display("FAIL bp_count: got %0d words within budget, expected 16", n);
        end
        checks++;
        if (m_axis_tvalid !== 1'b0 || sts_data !== {12'd16, 1'b0}) begin
            fails++;
            $display("FAIL bp_done: valid=%b sts=%h, expected 0 %h", m_axis_tvalid, sts_data, {12'd16, 1'b0});
        end
        m_axis_tready = 1'b1;
    endtask

    task automatic test_len0();
        m_axis_tready = 1'b1;
        start_readout(12'h123, 12'd0);
        tick();
        tick();
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h123 || m_axis_tlast !== 1'b1) begin
            fails++;
            $display("FAIL len0_word: valid=%b data=%h last=%b, expected 1 00000123 1",
                     m_axis_tvalid, m_axis_tdata, m_axis_tlast);
        end
        tick();
        checks++;
        if (m_axis_tvalid !== 1'b0 || sts_data !== {12'd1, 1'b0}) begin
            fails++;
            $display("FAIL len0_done: valid=%b sts=%h, expected 0 002", m_axis_tvalid, sts_data);
        end
    endtask

    task automatic test_full();
        int          errs = 0;
        int          bad  = -1;
        logic [11:0] e;
        m_axis_tready = 1'b1;
        start_readout(12'h800, 12'hFFF);
        tick();
        tick();
        for (int i = 0; i < 4096; i++) begin
            e = 12'h800 + 12'(i);
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== {20'h0, e} || m_axis_tlast !== (i == 4095)) begin
                if (bad < 0) bad = i;
                errs++;
            end
            if (i == 4095) begin
                checks++;
                if (m_axis_tdata !== 32'h7FF || m_axis_tlast !== 1'b1) begin
                    fails++;
                    $display("FAIL full_last: data=%h last=%b, expected 000007ff 1", m_axis_tdata, m_axis_tlast);
                end
            end
            tick();
        end
        checks++;
        if (errs !== 0) begin
            fails++;
            $display("FAIL full_stream: %0d bad words, first at index %0d, expected 0", errs, bad);
        end
        checks++;
        if (sts_data !== 13'h0 || m_axis_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL full_done: sts=%h valid=%b, expected 0000 0", sts_data, m_axis_tvalid);
        end
    endtask

    task automatic test_reset_mid();
        m_axis_tready = 1'b1;
        start_readout(12'h200, 12'd31);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'(32'h200 + i)) begin
                fails++;
                $display("FAIL rmid_word%0d: valid=%b data=%h, expected 1 %h",
                         i, m_axis_tvalid, m_axis_tdata, 32'(32'h200 + i));
            end
            tick();
        end
        aresetn    = 1'b0;
        start_flag = 1'b1;
        tick();
        checks++;
        if (m_axis_tvalid !== 1'b0 || sts_data !== 13'h0 || bram_porta_addr !== 12'h0) begin
            fails++;
            $display("FAIL rmid_reset: valid=%b sts=%h addr=%h, expected 0 0000 000",
                     m_axis_tvalid, sts_data, bram_porta_addr);
        end
        tick();
        checks++;
        if (sts_data !== 13'h0) begin
            fails++;
            $display("FAIL rmid_start_in_reset: sts=%h expected 0000", sts_data);
        end
        aresetn    = 1'b1;
        start_flag = 1'b0;
        tick();
        start_readout(12'h050, 12'd2);
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'(32'h50 + i) || m_axis_tlast !== (i == 2)) begin
                fails++;
                $display("FAIL rmid_fresh%0d: valid=%b data=%h last=%b, expected 1 %h %b",
                         i, m_axis_tvalid, m_axis_tdata, m_axis_tlast, 32'(32'h50 + i), (i == 2));
            end
            tick();
        end
        checks++;
        if (sts_data !== {12'd3, 1'b0}) begin
            fails++;
            $display("FAIL rmid_done: sts=%h expected %h", sts_data, {12'd3, 1'b0});
        end
    endtask

    task automatic test_busy_start();
        m_axis_tready = 1'b1;
        start_readout(12'h300, 12'd3);
        start_addr = 12'h000;
        len_data   = 12'd0;
        start_flag = 1'b1;
        tick();
        start_flag = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'(32'h300 + i) || m_axis_tlast !== (i == 3)) begin
                fails++;
                $display("FAIL busy_word%0d: valid=%b data=%h last=%b, expected 1 %h %b",
                         i, m_axis_tvalid, m_axis_tdata, m_axis_tlast, 32'(32'h300 + i), (i == 3));
            end
            tick();
        end
        tick();
        tick();
        checks++;
        if (sts_data !== {12'd4, 1'b0} || m_axis_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL busy_idle: sts=%h valid=%b, expected %h 0", sts_data, m_axis_tvalid, {12'd4, 1'b0});
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] q[$];
        int          lasts = 0;
        m_axis_tready = 1'b1;
        start_addr    = 12'h400;
        len_data      = 12'd1;
        start_flag    = 1'b1;
        for (int it = 0; it < 40; it++) begin
            if (it == 12) start_flag = 1'b0;
            if (m_axis_tvalid) q.push_back({m_axis_tlast, m_axis_tdata});
            tick();
        end
        checks++;
        if (q.size() !== 6) begin
            fails++;
            $display("FAIL b2b_count: got %0d words, expected 6", q.size());
        end
        foreach (q[k]) begin
            if (q[k][32]) lasts++;
            checks++;
            if (q[k][31:0] !== 32'(32'h400 + (k % 2)) || q[k][32] !== (k % 2 == 1)) begin
                fails++;
                $display("FAIL b2b_word%0d: data=%h last=%b, expected %h %b",
                         k, q[k][31:0], q[k][32], 32'(32'h400 + (k % 2)), (k % 2 == 1));
            end
        end
        checks++;
        if (lasts !== 3 || sts_data[0] !== 1'b0) begin
            fails++;
            $display("FAIL b2b_tlasts: tlast count=%0d busy=%b, expected 3 0", lasts, sts_data[0]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_len0();
        test_full();
        test_reset_mid();
        test_busy_start();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
